// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared width, state encoding and default watchdog limit for the AES job arbiter
package aes_arb_pkg;
  localparam int AES_W = 128;
  localparam int TIMEOUT_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: combinational round-robin pick; the requester after last_ptr has highest priority
module aes_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);
  int c;
  // Walk from lowest to highest priority so the highest-priority hit overwrites the rest
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    c = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = (int'(last_ptr) + k) % N_REQ;
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        gnt_idx = ID_W'(c);
      end
    end
  end
endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin scheduler of N_REQ requesters onto one shared AES_top core.
// Define AES_ARB_TIMEOUT_EN to enable the BUSY watchdog (rsp_err on expiry).
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*AES_W-1:0] req_data,
  input  logic [N_REQ*AES_W-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [AES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   core_en,
  output logic [AES_W-1:0]       core_data,
  output logic [AES_W-1:0]       core_key,
  input  logic                   core_out_valid,
  input  logic [AES_W-1:0]       core_out
);
  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  last_q;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             accept, tmo, done;
  logic             core_en_q, rsp_valid_q, rsp_err_q;
  logic [AES_W-1:0] core_data_q, core_key_q, rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;

  aes_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req      (req_valid),
    .last_ptr (last_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign done      = (state_q == BUSY) && (core_out_valid || tmo);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] cnt_q;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge AES_clk)
    cnt_q <= (AES_rst || state_q != BUSY) ? '0 : cnt_q + 1'b1;
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (accept ? BUSY : IDLE) :
              (state_q == BUSY) ? (done ? RESP : BUSY) :
              (rsp_ready ? IDLE : RESP);
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      core_en_q   <= 1'b0;
      core_data_q <= '0;
      core_key_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_en_q   <= state_d == BUSY;
      rsp_valid_q <= state_d == RESP;
      if (accept) begin
        last_q      <= gnt_idx;
        core_data_q <= req_data[int'(gnt_idx)*AES_W +: AES_W];
        core_key_q  <= req_key[int'(gnt_idx)*AES_W +: AES_W];
      end else if (done) begin
        core_data_q <= '0;
        core_key_q  <= '0;
      end
      // A real result beats a watchdog expiry in the same cycle
      if (done) begin
        rsp_id_q   <= last_q;
        rsp_data_q <= core_out_valid ? core_out : '0;
        rsp_err_q  <= tmo && !core_out_valid;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_id_q   <= '0;
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign core_en   = core_en_q;
  assign core_data = core_data_q;
  assign core_key  = core_key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb_aes_job_arbiter: directed plus randomized checks of aes_job_arbiter against an AES_top stub and a job-level model
module tb_aes_job_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;
`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic AES_clk = 1'b0, AES_rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [127:0] dat [NR];
  logic [127:0] key [NR];
  logic [NR*128-1:0] req_data, req_key;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, core_en, core_out_valid;
  logic [0:0] rsp_id;
  logic [127:0] rsp_data, core_data, core_key, core_out;
  logic stray_v = 1'b0;
  logic [127:0] stray_val = '0;
  int scnt = 0, stub_lat = 11;
  int tests = 0, fails = 0, ref_last = NR - 1, got_id = 0;

  assign req_data = {dat[1], dat[0]};
  assign req_key  = {key[1], key[0]};

  aes_job_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .core_en(core_en),
    .core_data(core_data), .core_key(core_key), .core_out_valid(core_out_valid), .core_out(core_out)
  );

  always #5 AES_clk = ~AES_clk;

  function automatic logic [127:0] stub_fn(logic [127:0] d, logic [127:0] k);
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  // AES_top stand-in: result appears L cycles after core_en rises, held only while enabled
  always @(posedge AES_clk) scnt <= core_en ? scnt + 1 : 0;
  assign core_out_valid = (core_en && scnt == stub_lat) || stray_v;
  assign core_out = stray_v ? stray_val : stub_fn(core_data, core_key);

  task automatic tick;
    @(posedge AES_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [NR-1:0] m, int last);
    for (int k = 1; k <= NR; k++)
      if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [127:0] rnd128;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic job(input logic [NR-1:0] vm, input int hold, input int lat);
    int g, n, en_cnt, exp_n;
    bit exp_err;
    logic [127:0] exp_data, d0;
    stub_lat = lat;
    req_valid = vm;
    #1;
    g = pick(vm, ref_last);
    exp_err = TMO_EN && (lat < 0 || lat >= TO);
    exp_n = exp_err ? TO + 1 : lat + 2;
    exp_data = exp_err ? '0 : stub_fn(dat[g], key[g]);
    chk("grant", req_ready, 128'(1 << g));
    tick;
    ref_last = g;
    chk("en_rise", core_en, 1);
    chk("core_data", core_data, dat[g]);
    chk("core_key", core_key, key[g]);
    dat[g] = rnd128();
    key[g] = rnd128();
    n = 1;
    en_cnt = 0;
    while (!rsp_valid && n < 300) begin
      if (core_en) en_cnt++;
      tick;
      n++;
    end
    got_id = int'(rsp_id);
    chk("rsp_latency", n, exp_n);
    chk("en_cycles", en_cnt, exp_n - 1);
    chk("en_drop", core_en, 0);
    chk("rsp_id", rsp_id, g);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, exp_err);
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, g);
      chk("bp_data", rsp_data, d0);
      chk("bp_ready", req_ready, 0);
      chk("bp_en", core_en, 0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("gap_en", core_en, 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      dat[i] = rnd128();
      key[i] = rnd128();
    end
    tick;
    tick;
    chk("rst_outs", {rsp_valid, core_en, rsp_err, req_ready, rsp_id}, 0);
    chk("rst_data", rsp_data | core_data | core_key, 0);
    AES_rst = 1'b0;
    dat[0] = 128'h0000007c_00000000_00000000_00000000;
    key[0] = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    job(2'b01, 0, 11);
    req_valid = '0;
    stray_val = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
    stray_v = 1'b1;
    tick;
    stray_v = 1'b0;
    chk("stray_rsp", rsp_valid, 0);
    tick;
    chk("stray_rsp2", {rsp_valid, core_en}, 0);
    req_valid = 2'b01;
    #1;
    chk("drop_cand", req_ready, 2'b10 >> 1);
    req_valid = '0;
    tick;
    chk("drop_en", core_en, 0);
    job(2'b11, 20, 11);
    req_valid = 2'b01;
    tick;
    req_valid = '0;
    repeat (5) tick;
    chk("mid_en", core_en, 1);
    AES_rst = 1'b1;
    tick;
    chk("mid_rst_outs", {rsp_valid, core_en, rsp_err, req_ready, rsp_id}, 0);
    chk("mid_rst_data", rsp_data | core_data | core_key, 0);
    AES_rst = 1'b0;
    ref_last = NR - 1;
    for (int i = 0; i < 4; i++) begin
      job(2'b11, 0, 11);
      chk("cont_seq", got_id, i % 2);
    end
    if (TMO_EN) begin
      job(2'b01, 1, -1);
      job(2'b10, 0, 15);
    end
    repeat (20) job(NR'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 20));
    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
